mask_roi_stream_v4: RTL and testbench

- Successor to the single-window mask gating and row-address muxing between the Exposure and Readout engines.
- Selects the sensor ROWADD from the readout or exposure address, then produces mSTREAM from up to NUM_ROI programmable row windows, each with its own mask.
- Window configuration is double-buffered: host writes go to a staging bank, and the active bank updates only at a frame boundary.
- Sits between Exposure_v3/Readout_v3 and the sensor pad drivers.

---
 rtl/mask_roi_stream_v4.sv | 145 ++++++++++++++
 tb/tb_mask_roi_stream_v4.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mask_roi_stream_v4.sv
// Row-address mux plus multi-window ROI mask gating between the exposure/readout engines and the sensor pads.
// Window configuration is double-buffered: staging writes reach the active bank only on frame_sync.
module mask_roi_stream_v4 #(
   parameter int MASK_W     = 16,
   parameter int ROW_W      = 10,
   parameter int NUM_ROI    = 4,
   parameter int ROW_OFFSET = 323,
   localparam int IDX_W     = (NUM_ROI > 1) ? $clog2(NUM_ROI) : 1
) (
   input  logic               CLK,
   input  logic               rst_n,
   input  logic               re_busy,
   input  logic               btm_array,
   input  logic [ROW_W-1:0]   rowadd_ro,
   input  logic [ROW_W-1:0]   rowadd_expt,
   input  logic [ROW_W-1:0]   rowadd_expb,
   input  logic               pixglob_res,
   input  logic               frame_sync,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic               cfg_en,
   input  logic [ROW_W-1:0]   cfg_row_start,
   input  logic [ROW_W-1:0]   cfg_row_stop,
   input  logic [MASK_W-1:0]  cfg_mask,
   input  logic [MASK_W-1:0]  mask_default,
   output logic [ROW_W-1:0]   ROWADD,
   output logic [MASK_W-1:0]  mSTREAM,
   output logic [NUM_ROI-1:0] roi_hit,
   output logic               cfg_pending,
   output logic [15:0]        gated_rows
);

   typedef struct packed {
      logic              en;
      logic [ROW_W-1:0]  start;
      logic [ROW_W-1:0]  stop;
      logic [MASK_W-1:0] mask;
   } win_t;

   win_t               r_stg [NUM_ROI];
   win_t               r_act [NUM_ROI];
   logic               r_pending;

   logic [ROW_W-1:0]   r_rowadd;
   logic               r_re_busy_d;
   logic               r_pix_d;
   logic [ROW_W-1:0]   r_rowadd_prev;
   logic [MASK_W-1:0]  r_mstream;
   logic [NUM_ROI-1:0] r_roi_hit;
   logic [15:0]        r_gated;
   logic               r_first;

   logic [ROW_W-1:0]   w_rowadd_nxt;
   logic [NUM_ROI-1:0] w_hit;
   logic               w_any_hit;
   logic [MASK_W-1:0]  w_sel_mask;
   logic [MASK_W-1:0]  w_mstream;
   logic               w_cfg_valid;
   logic               w_count;

   assign w_cfg_valid = cfg_we && (int'(cfg_idx) < NUM_ROI);

   // NOTE: both banks are reset so no stale window can hit before the first config write plus frame_sync.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ROI; i++) begin
            r_stg[i] <= '0;
            r_act[i] <= '0;
         end
         r_pending <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make the frame_sync copy see pre-write staging contents.
         if (frame_sync) begin
            for (int i = 0; i < NUM_ROI; i++) r_act[i] <= r_stg[i];
         end
         if (w_cfg_valid) r_stg[cfg_idx] <= '{cfg_en, cfg_row_start, cfg_row_stop, cfg_mask};
         if (frame_sync)       r_pending <= w_cfg_valid;
         else if (w_cfg_valid) r_pending <= 1'b1;
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns and no latch is inferred.
      w_rowadd_nxt = ROW_W'(ROW_OFFSET) - rowadd_expt;
      if (re_busy)        w_rowadd_nxt = {rowadd_ro[ROW_W-1:1], btm_array ? 1'b0 : rowadd_ro[0]};
      else if (btm_array) w_rowadd_nxt = {rowadd_expb[ROW_W-1:3], 3'b010};
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_rowadd    <= '0;
         r_re_busy_d <= 1'b0;
         r_pix_d     <= 1'b0;
      end else begin
         r_rowadd    <= w_rowadd_nxt;
         r_re_busy_d <= re_busy;
         r_pix_d     <= pixglob_res;
      end
   end

   always_comb begin
      w_hit = '0;
      for (int i = 0; i < NUM_ROI; i++)
         w_hit[i] = r_act[i].en && (r_rowadd > r_act[i].start) && (r_rowadd < r_act[i].stop);
   end

   // Descending scan leaves the lowest-index hit's mask in place.
   always_comb begin
      w_sel_mask = mask_default;
      for (int i = NUM_ROI - 1; i >= 0; i--)
         if (w_hit[i]) w_sel_mask = r_act[i].mask;
   end

   assign w_any_hit = |w_hit;
   assign w_mstream = {MASK_W{r_pix_d}} | (r_re_busy_d ? '0 : w_sel_mask);
   assign w_count   = w_any_hit && !r_re_busy_d && ((r_rowadd != r_rowadd_prev) || r_first);

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_mstream     <= '0;
         r_roi_hit     <= '0;
         r_rowadd_prev <= '0;
         r_gated       <= '0;
         r_first       <= 1'b0;
      end else begin
         r_mstream     <= w_mstream;
         r_roi_hit     <= w_hit;
         r_rowadd_prev <= r_rowadd;
         if (frame_sync) begin
            r_gated <= '0;
            r_first <= 1'b1;
         end else if (w_count) begin
            if (r_gated != 16'hFFFF) r_gated <= r_gated + 16'd1;
            r_first <= 1'b0;
         end
      end
   end

   assign ROWADD      = r_rowadd;
   assign mSTREAM     = r_mstream;
   assign roi_hit     = r_roi_hit;
   assign cfg_pending = r_pending;
   assign gated_rows  = r_gated;

endmodule

// File: tb/tb_mask_roi_stream_v4.sv
// Directed bench for mask_roi_stream_v4: row muxing, banked ROI windows, pixglob override and gated-row counting.
module tb_mask_roi_stream_v4;

   logic        CLK = 1'b0;
   logic        rst_n;
   logic        re_busy, btm_array, pixglob_res, frame_sync, cfg_we, cfg_en;
   logic [9:0]  rowadd_ro, rowadd_expt, rowadd_expb, cfg_row_start, cfg_row_stop;
   logic [1:0]  cfg_idx;
   logic [15:0] cfg_mask, mask_default;
   logic [9:0]  ROWADD;
   logic [15:0] mSTREAM;
   logic [3:0]  roi_hit;
   logic        cfg_pending;
   logic [15:0] gated_rows;

   int n_vec = 0;
   int n_err = 0;

   mask_roi_stream_v4 dut (
      .CLK(CLK), .rst_n(rst_n), .re_busy(re_busy), .btm_array(btm_array),
      .rowadd_ro(rowadd_ro), .rowadd_expt(rowadd_expt), .rowadd_expb(rowadd_expb),
      .pixglob_res(pixglob_res), .frame_sync(frame_sync), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_en(cfg_en), .cfg_row_start(cfg_row_start), .cfg_row_stop(cfg_row_stop),
      .cfg_mask(cfg_mask), .mask_default(mask_default), .ROWADD(ROWADD), .mSTREAM(mSTREAM),
      .roi_hit(roi_hit), .cfg_pending(cfg_pending), .gated_rows(gated_rows)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Exposure-top mode: ROWADD = 323 - expt, so pick expt to land on the wanted row.
   task automatic set_row(input logic [9:0] r);
      rowadd_expt = 10'd323 - r;
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic en, input logic [9:0] lo,
                            input logic [9:0] hi, input logic [15:0] m);
      cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_row_start = lo; cfg_row_stop = hi; cfg_mask = m;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic frame_pulse();
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; re_busy = 0; btm_array = 0; pixglob_res = 0; frame_sync = 0; cfg_we = 0;
      cfg_en = 0; cfg_idx = 0; cfg_row_start = 0; cfg_row_stop = 0; cfg_mask = 0;
      rowadd_ro = 0; rowadd_expt = 0; rowadd_expb = 0; mask_default = 16'hAAAA;
      tick(); tick();
      n_vec++; if (ROWADD !== 10'd0) begin n_err++; $display("FAIL rst_rowadd: got %0d want 0", ROWADD); end
      n_vec++; if (mSTREAM !== 16'h0) begin n_err++; $display("FAIL rst_mstream: got %h want 0000", mSTREAM); end
      n_vec++; if (roi_hit !== 4'b0) begin n_err++; $display("FAIL rst_hit: got %b want 0000", roi_hit); end
      n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %b want 0", cfg_pending); end
      n_vec++; if (gated_rows !== 16'h0) begin n_err++; $display("FAIL rst_gated: got %0d want 0", gated_rows); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_rowadd();
      re_busy = 1; btm_array = 1; rowadd_ro = 10'd323;
      tick();
      n_vec++; if (ROWADD !== 10'd322) begin n_err++; $display("FAIL ro_btm: got %0d want 322", ROWADD); end
      tick();
      n_vec++; if (mSTREAM !== 16'h0) begin n_err++; $display("FAIL ro_mstream: got %h want 0000", mSTREAM); end
      btm_array = 0;
      tick();
      n_vec++; if (ROWADD !== 10'd323) begin n_err++; $display("FAIL ro_top: got %0d want 323", ROWADD); end
      re_busy = 0; rowadd_expt = 10'd3;
      tick();
      n_vec++; if (ROWADD !== 10'd320) begin n_err++; $display("FAIL expt_3: got %0d want 320", ROWADD); end
      tick();
      n_vec++; if (mSTREAM !== 16'hAAAA) begin n_err++; $display("FAIL default_mask: got %h want AAAA", mSTREAM); end
      rowadd_expt = 10'd400;
      tick();
      n_vec++; if (ROWADD !== 10'd947) begin n_err++; $display("FAIL expt_wrap: got %0d want 947", ROWADD); end
      btm_array = 1; rowadd_expb = 10'h3FF;
      tick();
      n_vec++; if (ROWADD !== 10'h3FA) begin n_err++; $display("FAIL expb: got %h want 3fa", ROWADD); end
      btm_array = 0;
   endtask

   task automatic test_config();
      cfg_write(2'd0, 1'b1, 10'd400, 10'd440, 16'h5555);
      n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL pend_set: got %b want 1", cfg_pending); end
      set_row(10'd420); tick(); tick();
      n_vec++; if (mSTREAM !== 16'hAAAA) begin n_err++; $display("FAIL staged_only: got %h want AAAA", mSTREAM); end
      frame_pulse();
      n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL pend_clr: got %b want 0", cfg_pending); end
      tick();
      n_vec++; if (mSTREAM !== 16'h5555) begin n_err++; $display("FAIL win_420: got %h want 5555", mSTREAM); end
      n_vec++; if (roi_hit !== 4'b0001) begin n_err++; $display("FAIL hit_420: got %b want 0001", roi_hit); end
      set_row(10'd400); tick(); tick();
      n_vec++; if (mSTREAM !== 16'hAAAA) begin n_err++; $display("FAIL edge_400: got %h want AAAA", mSTREAM); end
      set_row(10'd440); tick(); tick();
      n_vec++; if (mSTREAM !== 16'hAAAA) begin n_err++; $display("FAIL edge_440: got %h want AAAA", mSTREAM); end
   endtask

   task automatic test_overlap();
      cfg_write(2'd0, 1'b1, 10'd100, 10'd200, 16'h000F);
      cfg_write(2'd1, 1'b1, 10'd150, 10'd250, 16'hF000);
      frame_pulse();
      set_row(10'd175); tick(); tick();
      n_vec++; if (roi_hit !== 4'b0011) begin n_err++; $display("FAIL ovl_hit: got %b want 0011", roi_hit); end
      n_vec++; if (mSTREAM !== 16'h000F) begin n_err++; $display("FAIL ovl_mask: got %h want 000F", mSTREAM); end
      set_row(10'd220); tick(); tick();
      n_vec++; if (roi_hit !== 4'b0010) begin n_err++; $display("FAIL w1_hit: got %b want 0010", roi_hit); end
      n_vec++; if (mSTREAM !== 16'hF000) begin n_err++; $display("FAIL w1_mask: got %h want F000", mSTREAM); end
      cfg_write(2'd2, 1'b1, 10'd300, 10'd301, 16'h1234);
      frame_pulse();
      set_row(10'd301); tick(); tick();
      n_vec++; if (roi_hit !== 4'b0000) begin n_err++; $display("FAIL narrow_hit: got %b want 0000", roi_hit); end
      n_vec++; if (mSTREAM !== 16'hAAAA) begin n_err++; $display("FAIL narrow_mask: got %h want AAAA", mSTREAM); end
   endtask

   task automatic test_pixglob();
      set_row(10'd175); pixglob_res = 1; tick(); tick();
      n_vec++; if (mSTREAM !== 16'hFFFF) begin n_err++; $display("FAIL pix_win: got %h want FFFF", mSTREAM); end
      re_busy = 1; rowadd_ro = 10'd5; tick(); tick();
      n_vec++; if (mSTREAM !== 16'hFFFF) begin n_err++; $display("FAIL pix_ro: got %h want FFFF", mSTREAM); end
      pixglob_res = 0; tick(); tick();
      n_vec++; if (mSTREAM !== 16'h0000) begin n_err++; $display("FAIL ro_zero: got %h want 0000", mSTREAM); end
      re_busy = 0;
   endtask

   task automatic test_simul_cfg();
      cfg_we = 1; cfg_idx = 2'd0; cfg_en = 1; cfg_row_start = 10'd100; cfg_row_stop = 10'd200;
      cfg_mask = 16'h00F0; frame_sync = 1;
      tick();
      cfg_we = 0; frame_sync = 0;
      n_vec++; if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL simul_pend: got %b want 1", cfg_pending); end
      set_row(10'd175); tick(); tick();
      n_vec++; if (mSTREAM !== 16'h000F) begin n_err++; $display("FAIL simul_old: got %h want 000F", mSTREAM); end
      frame_pulse();
      n_vec++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL simul_pclr: got %b want 0", cfg_pending); end
      tick();
      n_vec++; if (mSTREAM !== 16'h00F0) begin n_err++; $display("FAIL simul_new: got %h want 00F0", mSTREAM); end
   endtask

   task automatic test_gated_rows();
      set_row(10'd50); repeat (3) tick();
      frame_pulse(); tick();
      n_vec++; if (gated_rows !== 16'd0) begin n_err++; $display("FAIL gated_start: got %0d want 0", gated_rows); end
      for (int r = 110; r < 130; r++) begin
         set_row(10'(r));
         repeat (3) tick();
      end
      set_row(10'd50); repeat (3) tick();
      n_vec++; if (gated_rows !== 16'd20) begin n_err++; $display("FAIL gated_sweep: got %0d want 20", gated_rows); end
      frame_pulse();
      n_vec++; if (gated_rows !== 16'd0) begin n_err++; $display("FAIL gated_clr: got %0d want 0", gated_rows); end
   endtask

   task automatic test_saturate_and_reset();
      logic flip;
      flip = 0;
      for (int i = 0; i < 6; i++) begin
         set_row(flip ? 10'd151 : 10'd150); flip = ~flip; tick();
      end
      frame_sync = 1; set_row(flip ? 10'd151 : 10'd150); flip = ~flip; tick(); frame_sync = 0;
      n_vec++; if (gated_rows !== 16'd0) begin n_err++; $display("FAIL clr_prio: got %0d want 0", gated_rows); end
      set_row(flip ? 10'd151 : 10'd150); flip = ~flip; tick();
      n_vec++; if (gated_rows !== 16'd1) begin n_err++; $display("FAIL first_hit: got %0d want 1", gated_rows); end
      for (int i = 0; i < 70000; i++) begin
         set_row(flip ? 10'd151 : 10'd150); flip = ~flip; tick();
      end
      n_vec++; if (gated_rows !== 16'hFFFF) begin n_err++; $display("FAIL gated_sat: got %h want FFFF", gated_rows); end
      n_vec++; if (mSTREAM !== 16'h00F0) begin n_err++; $display("FAIL pre_rst: got %h want 00F0", mSTREAM); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (ROWADD !== 10'd0) begin n_err++; $display("FAIL mid_rst_row: got %0d want 0", ROWADD); end
      n_vec++; if (mSTREAM !== 16'h0) begin n_err++; $display("FAIL mid_rst_ms: got %h want 0000", mSTREAM); end
      n_vec++; if (roi_hit !== 4'b0) begin n_err++; $display("FAIL mid_rst_hit: got %b want 0000", roi_hit); end
      n_vec++; if (gated_rows !== 16'h0) begin n_err++; $display("FAIL mid_rst_gated: got %0d want 0", gated_rows); end
      tick();
      rst_n = 1'b1; set_row(10'd151);
      repeat (3) tick();
      n_vec++; if (ROWADD !== 10'd151) begin n_err++; $display("FAIL post_rst_row: got %0d want 151", ROWADD); end
      n_vec++; if (mSTREAM !== 16'hAAAA) begin n_err++; $display("FAIL post_rst_ms: got %h want AAAA", mSTREAM); end
      n_vec++; if (roi_hit !== 4'b0) begin n_err++; $display("FAIL post_rst_hit: got %b want 0000", roi_hit); end
   endtask

   initial begin
      test_reset();
      test_rowadd();
      test_config();
      test_overlap();
      test_pixglob();
      test_simul_cfg();
      test_gated_rows();
      test_saturate_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
